// File: rtl/sync_debounce_if.sv
// Bundles the raw per-channel inputs with the debounced level and edge-pulse outputs.
// Latency: none (wires only).
// Backpressure: none; every signal is a plain level or a single-cycle pulse.
interface sync_debounce_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] async_in;
    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic             any_rise;

    // Source side: drives raw levels, observes the debounced results.
    modport master (
        output async_in,
        input  level,
        input  rise,
        input  fall,
        input  any_rise
    );

    // Debouncer side.
    modport slave (
        input  async_in,
        output level,
        output rise,
        output fall,
        output any_rise
    );
endinterface

// File: rtl/sync_debounce.sv
// Per-channel synchronizer + stability counter that emits a debounced level and rise/fall pulses.
// Latency: a held input change reaches level after STAGES + DB_CYCLES - 1 clk edges.
// Backpressure: none; outputs are free-running levels and one-cycle pulses.
module sync_debounce #(
    parameter int WIDTH     = 4,
    parameter int STAGES    = 2,
    parameter int DB_CYCLES = 4
) (
    input  logic           clk,
    input  logic           reset,
    sync_debounce_if.slave bus
);
    localparam int CW = $clog2(DB_CYCLES + 1);
    // Counter value at which the next differing sample is accepted.
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [WIDTH-1:0] sync_q [STAGES];
    logic [WIDTH-1:0] s;
    logic [CW-1:0]    cnt_q  [WIDTH];
    logic [CW-1:0]    cnt_d  [WIDTH];
    logic [WIDTH-1:0] level_q, level_d;
    logic [WIDTH-1:0] rise_q,  rise_d;
    logic [WIDTH-1:0] fall_q,  fall_d;
    logic             any_rise_q;

    // Last flop of the chain is the synchronized sample used by the debouncer.
    assign s = sync_q[STAGES-1];

    // Plain flop chain per channel; nothing sits between stages.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int j = 0; j < STAGES; j++) begin
                sync_q[j] <= '0;
            end
        end else begin
            sync_q[0] <= bus.async_in;
            for (int j = 1; j < STAGES; j++) begin
                sync_q[j] <= sync_q[j-1];
            end
        end
    end

    // Count consecutive samples that disagree with the current level; accept on the last one.
    always_comb begin
        level_d = level_q;
        rise_d  = '0;
        fall_d  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (s[i] != level_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    level_d[i] = s[i];
                    rise_d[i]  = s[i];
                    fall_d[i]  = ~s[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    // Debounce state and registered outputs; reset overrides any acceptance in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            level_q    <= '0;
            rise_q     <= '0;
            fall_q     <= '0;
            any_rise_q <= 1'b0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            level_q    <= level_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            any_rise_q <= |rise_d;
        end
    end

    assign bus.level    = level_q;
    assign bus.rise     = rise_q;
    assign bus.fall     = fall_q;
    assign bus.any_rise = any_rise_q;
endmodule

// File: tb/tb_sync_debounce.sv
// Self-checking bench for sync_debounce with default parameters.
// Reference model: delay line for the synchronizer plus a sliding window of the last DB samples.
// Scenarios use fixed expectations; a long randomized run is checked against the model.
module tb_sync_debounce;
    localparam int WIDTH  = 4;
    localparam int STAGES = 2;
    localparam int DB     = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sync_debounce_if #(.WIDTH(WIDTH)) bus ();

    sync_debounce #(.WIDTH(WIDTH), .STAGES(STAGES), .DB_CYCLES(DB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_run  = 0;
    int n_fail = 0;

    // Model state: raw input delay line, window of the last DB synchronized samples, outputs.
    logic [WIDTH-1:0] m_pipe [STAGES];
    logic [WIDTH-1:0] m_win  [DB];
    logic [WIDTH-1:0] m_lvl, m_rise, m_fall;
    logic             m_any;

    // A channel flips when every one of the last DB synchronized samples disagreed with its level.
    function automatic void model_edge();
        logic [WIDTH-1:0] s_cur, flip;
        if (reset) begin
            for (int j = 0; j < STAGES; j++) m_pipe[j] = '0;
            for (int k = 0; k < DB; k++) m_win[k] = '0;
            m_lvl = '0; m_rise = '0; m_fall = '0; m_any = 1'b0;
        end else begin
            s_cur = m_pipe[STAGES-1];
            for (int k = DB-1; k > 0; k--) m_win[k] = m_win[k-1];
            m_win[0] = s_cur;
            flip = '1;
            for (int k = 0; k < DB; k++) flip &= (m_win[k] ^ m_lvl);
            m_rise = flip & ~m_lvl;
            m_fall = flip & m_lvl;
            m_lvl  = m_lvl ^ flip;
            m_any  = |m_rise;
            for (int j = STAGES-1; j > 0; j--) m_pipe[j] = m_pipe[j-1];
            m_pipe[0] = bus.async_in;
        end
    endfunction

    // One clock edge: advance the model with the inputs that were stable at the edge, settle 1ns.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.async_in = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.async_in = 4'b1111;
        for (int t = 1; t <= 3; t++) begin
            tick();
            n_run++;
            if ({bus.level, bus.rise, bus.fall, bus.any_rise} !== 13'b0) begin
                n_fail++;
                $display("FAIL reset t=%0d got level=%b rise=%b fall=%b any=%b want all 0",
                         t, bus.level, bus.rise, bus.fall, bus.any_rise);
            end
        end
        bus.async_in = '0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_single_rise();
        logic [WIDTH-1:0] el, er;
        do_reset();
        bus.async_in = 4'b0001;
        for (int t = 1; t <= 9; t++) begin
            tick();
            el = (t >= 6) ? 4'b0001 : 4'b0000;
            er = (t == 6) ? 4'b0001 : 4'b0000;
            n_run++;
            if (bus.level !== el || bus.rise !== er || bus.fall !== 4'b0 || bus.any_rise !== (t == 6)) begin
                n_fail++;
                $display("FAIL single_rise t=%0d got level=%b rise=%b fall=%b any=%b want level=%b rise=%b fall=0000 any=%b",
                         t, bus.level, bus.rise, bus.fall, bus.any_rise, el, er, (t == 6));
            end
            n_run++;
            if ({bus.level, bus.rise, bus.fall, bus.any_rise} !== {m_lvl, m_rise, m_fall, m_any}) begin
                n_fail++;
                $display("FAIL model_single_rise t=%0d got %b/%b/%b/%b want %b/%b/%b/%b", t,
                         bus.level, bus.rise, bus.fall, bus.any_rise, m_lvl, m_rise, m_fall, m_any);
            end
        end
    endtask

    task automatic test_reset_release();
        logic [WIDTH-1:0] el, er;
        reset = 1'b1;
        bus.async_in = 4'b1111;
        tick();
        tick();
        reset = 1'b0;
        for (int t = 1; t <= 8; t++) begin
            tick();
            el = (t >= 6) ? 4'b1111 : 4'b0000;
            er = (t == 6) ? 4'b1111 : 4'b0000;
            n_run++;
            if (bus.level !== el || bus.rise !== er || bus.any_rise !== (t == 6)) begin
                n_fail++;
                $display("FAIL reset_release t=%0d got level=%b rise=%b any=%b want level=%b rise=%b any=%b",
                         t, bus.level, bus.rise, bus.any_rise, el, er, (t == 6));
            end
        end
    endtask

    task automatic test_glitch();
        do_reset();
        for (int t = 1; t <= 12; t++) begin
            bus.async_in = (t <= 3) ? 4'b0001 : 4'b0000;
            tick();
            n_run++;
            if ({bus.level, bus.rise, bus.fall, bus.any_rise} !== 13'b0) begin
                n_fail++;
                $display("FAIL glitch t=%0d got level=%b rise=%b fall=%b any=%b want all 0",
                         t, bus.level, bus.rise, bus.fall, bus.any_rise);
            end
        end
    endtask

    task automatic test_fall();
        logic [WIDTH-1:0] el, ef;
        do_reset();
        bus.async_in = 4'b0100;
        for (int t = 1; t <= 7; t++) tick();
        n_run++;
        if (bus.level !== 4'b0100) begin
            n_fail++;
            $display("FAIL fall_setup got level=%b want 0100", bus.level);
        end
        bus.async_in = 4'b0000;
        for (int t = 1; t <= 8; t++) begin
            tick();
            el = (t >= 6) ? 4'b0000 : 4'b0100;
            ef = (t == 6) ? 4'b0100 : 4'b0000;
            n_run++;
            if (bus.level !== el || bus.fall !== ef || bus.rise !== 4'b0 || bus.any_rise !== 1'b0) begin
                n_fail++;
                $display("FAIL fall t=%0d got level=%b fall=%b rise=%b any=%b want level=%b fall=%b rise=0000 any=0",
                         t, bus.level, bus.fall, bus.rise, bus.any_rise, el, ef);
            end
        end
    endtask

    task automatic test_restart();
        logic [7:0] pat;
        logic [WIDTH-1:0] el, er;
        pat = 8'b1111_0111;
        do_reset();
        for (int t = 1; t <= 13; t++) begin
            bus.async_in = (t <= 8) ? {2'b00, pat[t-1], 1'b0} : 4'b0010;
            tick();
            el = (t >= 10) ? 4'b0010 : 4'b0000;
            er = (t == 10) ? 4'b0010 : 4'b0000;
            n_run++;
            if (bus.level !== el || bus.rise !== er || bus.fall !== 4'b0) begin
                n_fail++;
                $display("FAIL restart t=%0d got level=%b rise=%b fall=%b want level=%b rise=%b fall=0000",
                         t, bus.level, bus.rise, bus.fall, el, er);
            end
            n_run++;
            if ({bus.level, bus.rise, bus.fall, bus.any_rise} !== {m_lvl, m_rise, m_fall, m_any}) begin
                n_fail++;
                $display("FAIL model_restart t=%0d got %b/%b/%b/%b want %b/%b/%b/%b", t,
                         bus.level, bus.rise, bus.fall, bus.any_rise, m_lvl, m_rise, m_fall, m_any);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] er;
        do_reset();
        bus.async_in = 4'b1111;
        for (int t = 1; t <= 8; t++) begin
            tick();
            er = (t == 6) ? 4'b1111 : 4'b0000;
            n_run++;
            if (bus.rise !== er || bus.any_rise !== (t == 6)) begin
                n_fail++;
                $display("FAIL all_rise t=%0d got rise=%b any=%b want rise=%b any=%b",
                         t, bus.rise, bus.any_rise, er, (t == 6));
            end
        end
    endtask

    task automatic test_reset_midcount();
        logic [WIDTH-1:0] el, er;
        do_reset();
        bus.async_in = 4'b1000;
        for (int t = 1; t <= 4; t++) tick();
        reset = 1'b1;
        tick();
        n_run++;
        if ({bus.level, bus.rise, bus.fall, bus.any_rise} !== 13'b0) begin
            n_fail++;
            $display("FAIL midcount_reset got level=%b rise=%b fall=%b any=%b want all 0",
                     bus.level, bus.rise, bus.fall, bus.any_rise);
        end
        reset = 1'b0;
        bus.async_in = 4'b0000;
        for (int t = 1; t <= 10; t++) begin
            tick();
            n_run++;
            if ({bus.level, bus.rise, bus.fall, bus.any_rise} !== 13'b0) begin
                n_fail++;
                $display("FAIL midcount_quiet t=%0d got level=%b rise=%b fall=%b any=%b want all 0",
                         t, bus.level, bus.rise, bus.fall, bus.any_rise);
            end
        end
        bus.async_in = 4'b1000;
        for (int t = 1; t <= 7; t++) begin
            tick();
            el = (t >= 6) ? 4'b1000 : 4'b0000;
            er = (t == 6) ? 4'b1000 : 4'b0000;
            n_run++;
            if (bus.level !== el || bus.rise !== er) begin
                n_fail++;
                $display("FAIL midcount_reheld t=%0d got level=%b rise=%b want level=%b rise=%b",
                         t, bus.level, bus.rise, el, er);
            end
        end
    endtask

    task automatic test_random();
        int hold [WIDTH];
        logic [WIDTH-1:0] ain;
        do_reset();
        ain = '0;
        for (int i = 0; i < WIDTH; i++) hold[i] = $urandom_range(1, 8);
        for (int t = 1; t <= 3000; t++) begin
            for (int i = 0; i < WIDTH; i++) begin
                hold[i]--;
                if (hold[i] <= 0) begin
                    ain[i]  = ~ain[i];
                    hold[i] = $urandom_range(1, 9);
                end
            end
            bus.async_in = ain;
            reset = ($urandom_range(0, 249) == 0);
            tick();
            n_run++;
            if ({bus.level, bus.rise, bus.fall, bus.any_rise} !== {m_lvl, m_rise, m_fall, m_any}) begin
                n_fail++;
                $display("FAIL random t=%0d got %b/%b/%b/%b want %b/%b/%b/%b", t,
                         bus.level, bus.rise, bus.fall, bus.any_rise, m_lvl, m_rise, m_fall, m_any);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        bus.async_in = '0;
        for (int j = 0; j < STAGES; j++) m_pipe[j] = '0;
        for (int k = 0; k < DB; k++) m_win[k] = '0;
        m_lvl = '0; m_rise = '0; m_fall = '0; m_any = 1'b0;
        test_reset();
        test_single_rise();
        test_reset_release();
        test_glitch();
        test_fall();
        test_restart();
        test_back_to_back();
        test_reset_midcount();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/sync_debounce.md
SYNC_DEBOUNCE -- requirements
Module: sync_debounce

Interface
REQ-001 Parameter WIDTH, default 4, is the number of independent input channels; legal values are 1..32.
REQ-002 Parameter STAGES, default 2, is the synchronizer flop depth per channel; legal values are 2..4.
REQ-003 Parameter DB_CYCLES, default 4, is the number of consecutive stable synchronized cycles required to accept a new level; legal values are 1..255.
REQ-004 clk  input  1  is the sole clock; all state is updated on the posedge.
REQ-005 reset  input  1  is a synchronous, active-high reset; the clock is clk.
REQ-006 async_in  input  WIDTH  carries asynchronous raw levels, one bit per channel (buttons, switches).
REQ-007 level  output  WIDTH  carries the registered, debounced level per channel.
REQ-008 rise  output  WIDTH  carries a one-cycle pulse per channel when level goes 0->1.
REQ-009 fall  output  WIDTH  carries a one-cycle pulse per channel when level goes 1->0.
REQ-010 any_rise  output  1  is the registered OR of all rise bits, asserted in the same cycle as those rise bits.

Function
REQ-011 Each channel SHALL pass async_in[i] through a STAGES-deep flop chain; the last flop is s[i]. No logic SHALL sit between chain flops.
REQ-012 Each channel SHALL hold a counter cnt[i] of width clog2(DB_CYCLES+1), compared against the current level[i].
REQ-013 When s[i] == level[i], cnt[i] SHALL load 0 on that edge.
REQ-014 When s[i] != level[i] and cnt[i] < DB_CYCLES-1, cnt[i] SHALL increment by 1.
REQ-015 When s[i] != level[i] and cnt[i] == DB_CYCLES-1, the following SHALL all occur on that edge: level[i] <= s[i]; cnt[i] <= 0; rise[i] <= s[i]; fall[i] <= ~s[i].
REQ-016 In every other cycle, rise[i] and fall[i] SHALL be 0, so each pulse is exactly one cycle wide and rise/fall are never both high on one channel.
REQ-017 Latency: if async_in[i] settles before edge k and is held, level[i] SHALL change at edge k+STAGES+DB_CYCLES-1. With defaults this is edge k+5.
REQ-018 Glitch rejection: a deviation of s[i] lasting fewer than DB_CYCLES consecutive cycles SHALL NOT change level[i] and SHALL NOT pulse rise/fall. Any return of s[i] to level[i] SHALL restart the count from 0.
REQ-019 With DB_CYCLES == 1, every change of s[i] SHALL be accepted on the next edge, giving a plain (STAGES+1)-flop synchronizer with edge detect.
REQ-020 The counter SHALL never exceed DB_CYCLES-1 and SHALL never wrap.
REQ-021 Channels SHALL be fully independent: simultaneous transitions on several channels each follow REQ-013..018 with no interaction.
REQ-022 any_rise SHALL equal |rise in every cycle.

Reset
REQ-023 While reset is high at a posedge, all sync flops, cnt, level, rise, fall and any_rise SHALL load 0.
REQ-024 Reset SHALL take priority over all other updates, including an acceptance edge per REQ-015.
REQ-025 After reset deasserts with async_in[i] held at 1, level[i] SHALL go to 1 with a single rise pulse per REQ-017 latency, counted from the first non-reset edge.
REQ-026 Reset asserted mid-count SHALL discard the partial count; no pulse SHALL be emitted for the aborted transition.

Verification
REQ-027 Defaults, reset 2 cycles, async_in=4'b0001 held → level=0001 at edge 5 after the change, with rise=0001 and any_rise=1 for exactly that cycle.
REQ-028 Channel 0 high for 3 cycles only (s high 3 cycles < DB_CYCLES=4) → level, rise and fall stay 0 throughout.
REQ-029 Channel 2 held at 1, then dropped to 0 and held → fall=0100 for one cycle at edge 5 after the drop; level=0000.
REQ-030 Channel 1 toggling 1,1,1,0,1,1,1,1 into s → count restarts at the 0; level[1] rises only after the final 4 consecutive 1s.
REQ-031 All 4 channels rise in the same cycle → rise=1111 and any_rise=1 for one cycle, then rise=0000.
REQ-032 Reset asserted when cnt=2 on a pending channel → all outputs 0 on the next edge; no pulse occurs afterward unless the input is re-held for the full latency.
